// File: rtl/multicycle_control_unit_if.sv
// Bundle between the multi-cycle control unit and its datapath/memory neighbours.
// master = control unit side, slave = datapath/memory/testbench side.
interface multicycle_control_unit_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      instr;
  logic             br_less;
  logic             br_equal;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_wren;
  logic             ir_wren;
  logic             pc_wren;
  logic             pc_sel;
  logic             rd_wren;
  logic [1:0]       wb_sel;
  logic [1:0]       opa_sel;
  logic             opb_sel;
  logic             br_un;
  logic [3:0]       alu_op;
  logic [2:0]       state;
  logic [CNT_W-1:0] instret;
  logic             mem_fault;
  logic             illegal;

  modport master (
    input  instr, br_less, br_equal, mem_ready,
    output mem_req, mem_wren, ir_wren, pc_wren, pc_sel, rd_wren,
           wb_sel, opa_sel, opb_sel, br_un, alu_op, state, instret,
           mem_fault, illegal
  );

  modport slave (
    output instr, br_less, br_equal, mem_ready,
    input  mem_req, mem_wren, ir_wren, pc_wren, pc_sel, rd_wren,
           wb_sel, opa_sel, opb_sel, br_un, alu_op, state, instret,
           mem_fault, illegal
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with memory timeout and retire counter.
// Optional: define RV_CTRL_ILLEGAL_TRAP_EN to trap illegal encodings instead of running them as NOPs.
module multicycle_control_unit #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input logic                        i_clk,
  input logic                        i_rst,
  multicycle_control_unit_if.master  bus
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'b000,
    ST_DECODE = 3'b001,
    ST_EXEC   = 3'b010,
    ST_MEM    = 3'b011,
    ST_WB     = 3'b100,
    ST_TRAP   = 3'b111
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;
  localparam logic [3:0] ALU_NONE = 4'b1111;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);

  state_t             state_reg, state_next;
  logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
  logic [CNT_W-1:0]   instret_reg;
  logic               mem_fault_reg;
  logic               timeout_hit;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       instr_unused;

  assign opcode       = bus.instr[6:0];
  assign funct3       = bus.instr[14:12];
  assign funct7       = bus.instr[31:25];
  assign instr_unused = ^{bus.instr[24:15], bus.instr[11:7]};

  function automatic logic [3:0] f3_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  f3_alu = alt ? ALU_SUB : ALU_ADD;
      3'b001:  f3_alu = ALU_SLL;
      3'b010:  f3_alu = ALU_SLT;
      3'b011:  f3_alu = ALU_SLTU;
      3'b100:  f3_alu = ALU_XOR;
      3'b101:  f3_alu = alt ? ALU_SRA : ALU_SRL;
      3'b110:  f3_alu = ALU_OR;
      default: f3_alu = ALU_AND;
    endcase
  endfunction

  // Instruction decode: purely combinational from the IR.
  logic       instr_legal, is_branch, is_jump, is_load, is_store, br_taken;
  logic [3:0] alu_op;
  logic [1:0] opa_sel, wb_sel;
  logic       opb_sel, br_un;

  always_comb begin
    instr_legal = 1'b1;
    is_branch   = 1'b0;
    is_jump     = 1'b0;
    is_load     = 1'b0;
    is_store    = 1'b0;
    alu_op      = ALU_ADD;
    opa_sel     = 2'b00;
    opb_sel     = 1'b1;
    wb_sel      = 2'b00;
    br_un       = 1'b0;
    case (opcode)
      OPC_LUI:   opa_sel = 2'b10;
      OPC_AUIPC: opa_sel = 2'b01;
      OPC_JAL: begin
        opa_sel = 2'b01;
        is_jump = 1'b1;
        wb_sel  = 2'b10;
      end
      OPC_JALR: begin
        is_jump     = 1'b1;
        wb_sel      = 2'b10;
        instr_legal = (funct3 == 3'b000);
      end
      OPC_BRANCH: begin
        opa_sel     = 2'b01;
        is_branch   = 1'b1;
        br_un       = (funct3[2:1] == 2'b11);
        instr_legal = (funct3[2:1] != 2'b01);
      end
      OPC_LOAD: begin
        is_load = 1'b1;
        wb_sel  = 2'b01;
      end
      OPC_STORE: is_store = 1'b1;
      OPC_OP_IMM: begin
        // funct7 only carries meaning for the shift-immediate forms
        alu_op = f3_alu(funct3, (funct3 == 3'b101) && (funct7 == 7'b0100000));
        if (funct3 == 3'b001)
          instr_legal = (funct7 == 7'b0000000);
        else if (funct3 == 3'b101)
          instr_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
      end
      OPC_OP: begin
        opb_sel     = 1'b0;
        alu_op      = f3_alu(funct3, funct7 == 7'b0100000);
        instr_legal = (funct7 == 7'b0000000) ||
                      ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      default: begin
        instr_legal = 1'b0;
        opb_sel     = 1'b0;
      end
    endcase
    if (!instr_legal)
      alu_op = ALU_NONE;
  end

  always_comb begin
    case (funct3)
      3'b000:         br_taken = bus.br_equal;
      3'b001:         br_taken = ~bus.br_equal;
      3'b100, 3'b110: br_taken = bus.br_less;
      3'b101, 3'b111: br_taken = ~bus.br_less;
      default:        br_taken = 1'b0;
    endcase
  end

  generate
    if (MEM_TIMEOUT == 0) begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end else begin : g_timeout
      // Fault on the not-ready cycle that would make the count reach the limit; ready wins.
      assign timeout_hit = ~bus.mem_ready && (wait_cnt_reg == WAIT_W'(MEM_TIMEOUT - 1));
    end
  endgenerate

  logic mem_req, mem_wren, ir_wren, pc_wren, pc_sel, rd_wren, fault_set;
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
  logic illegal_reg, illegal_set;
`endif

  always_comb begin
    state_next = state_reg;
    mem_req    = 1'b0;
    mem_wren   = 1'b0;
    ir_wren    = 1'b0;
    pc_wren    = 1'b0;
    pc_sel     = 1'b0;
    rd_wren    = 1'b0;
    fault_set  = 1'b0;
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
    illegal_set = 1'b0;
`endif
    case (state_reg)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          ir_wren    = 1'b1;
          state_next = ST_DECODE;
        end else if (timeout_hit) begin
          fault_set  = 1'b1;
          state_next = ST_TRAP;
        end
      end
      ST_DECODE: begin
        if (instr_legal) begin
          state_next = ST_EXEC;
        end else begin
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
          illegal_set = 1'b1;
          state_next  = ST_TRAP;
`else
          pc_wren    = 1'b1;
          state_next = ST_FETCH;
`endif
        end
      end
      ST_EXEC: begin
        if (is_branch) begin
          pc_wren    = 1'b1;
          pc_sel     = br_taken;
          state_next = ST_FETCH;
        end else if (is_jump) begin
          rd_wren    = 1'b1;
          pc_wren    = 1'b1;
          pc_sel     = 1'b1;
          state_next = ST_FETCH;
        end else if (is_load || is_store) begin
          state_next = ST_MEM;
        end else begin
          state_next = ST_WB;
        end
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        mem_wren = is_store;
        if (bus.mem_ready) begin
          if (is_store) begin
            pc_wren    = 1'b1;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_WB;
          end
        end else if (timeout_hit) begin
          fault_set  = 1'b1;
          state_next = ST_TRAP;
        end
      end
      ST_WB: begin
        rd_wren    = 1'b1;
        pc_wren    = 1'b1;
        state_next = ST_FETCH;
      end
      ST_TRAP: state_next = ST_TRAP;
      default: state_next = ST_FETCH;
    endcase
  end

  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (state_next != state_reg)
      wait_cnt_next = '0;
    else if (((state_reg == ST_FETCH) || (state_reg == ST_MEM)) && !bus.mem_ready)
      wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
  end

  // Strobes are masked during reset so an abandoned access writes nothing.
  assign bus.mem_req  = mem_req  & ~i_rst;
  assign bus.mem_wren = mem_wren & ~i_rst;
  assign bus.ir_wren  = ir_wren  & ~i_rst;
  assign bus.pc_wren  = pc_wren  & ~i_rst;
  assign bus.rd_wren  = rd_wren  & ~i_rst;
  assign bus.pc_sel   = pc_sel;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= ST_FETCH;
      wait_cnt_reg  <= '0;
      instret_reg   <= '0;
      mem_fault_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (pc_wren)
        instret_reg <= instret_reg + CNT_W'(1);
      if (fault_set)
        mem_fault_reg <= 1'b1;
    end
  end

`ifdef RV_CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge i_clk) begin
    if (i_rst)
      illegal_reg <= 1'b0;
    else if (illegal_set)
      illegal_reg <= 1'b1;
  end
  assign bus.illegal = illegal_reg;
`else
  assign bus.illegal = 1'b0;
`endif

  assign bus.alu_op    = alu_op;
  assign bus.opa_sel   = opa_sel;
  assign bus.opb_sel   = opb_sel;
  assign bus.wb_sel    = wb_sel;
  assign bus.br_un     = br_un;
  assign bus.state     = state_reg;
  assign bus.instret   = instret_reg;
  assign bus.mem_fault = mem_fault_reg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: random RV32I stream, per-instruction
// expectations from an instruction-level model, checked at each retire/trap event.
module tb_multicycle_control_unit;
  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 4;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  multicycle_control_unit_if #(.CNT_W(CNT_W)) bus ();

  multicycle_control_unit #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  typedef enum int {K_ALU, K_BR, K_JMP, K_LD, K_ST, K_BAD, K_TIMEOUT} kind_t;

  typedef struct {
    int               id;
    kind_t            kind;
    logic [31:0]      instr;
    logic             trap;
    int               latency;
    logic [2:0]       state;
    logic             pc_sel;
    int               rd_cnt;
    int               req_cnt;
    int               wr_cnt;
    int               ir_cnt;
    logic             chk_dec;
    logic [3:0]       alu;
    logic [1:0]       opa;
    logic             opb;
    logic [1:0]       wb;
    logic             br_un;
    logic [CNT_W-1:0] instret;
    logic             fault;
    logic             illegal;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   retired  = 0;
  int   carry    = 0;
  int   txn_id   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // ---------------- reference model (instruction level) ----------------
  function automatic kind_t kind_of(input logic [31:0] ins);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    case (op)
      7'h37, 7'h17: return K_ALU;
      7'h6F: return K_JMP;
      7'h67: return (f3 == 3'd0) ? K_JMP : K_BAD;
      7'h63: return (f3 == 3'd2 || f3 == 3'd3) ? K_BAD : K_BR;
      7'h03: return K_LD;
      7'h23: return K_ST;
      7'h13: begin
        if (f3 == 3'd1 && f7 != 7'h00) return K_BAD;
        if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) return K_BAD;
        return K_ALU;
      end
      7'h33: begin
        if (f7 == 7'h00) return K_ALU;
        if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) return K_ALU;
        return K_BAD;
      end
      default: return K_BAD;
    endcase
  endfunction

  function automatic logic [3:0] model_alu(input logic [31:0] ins);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    if (op != 7'h33 && op != 7'h13) return 4'd0;
    if (f7 == 7'h20 && f3 == 3'd5) return 4'd7;
    if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd0) return 4'd1;
    case (f3)
      3'd0: return 4'd0;
      3'd1: return 4'd2;
      3'd2: return 4'd3;
      3'd3: return 4'd4;
      3'd4: return 4'd5;
      3'd5: return 4'd6;
      3'd6: return 4'd8;
      default: return 4'd9;
    endcase
  endfunction

  function automatic logic model_taken(input logic [2:0] f3, input logic less, input logic eq);
    if (f3 == 3'd0) return eq;
    if (f3 == 3'd1) return !eq;
    if (f3 == 3'd4 || f3 == 3'd6) return less;
    return !less;
  endfunction

  // ---------------- driver helpers ----------------
  task automatic cyc(input logic rdy);
    bus.mem_ready = rdy;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    bus.mem_ready = 1'b1;
    @(negedge i_clk);
    check("rst.mem_req", bus.mem_req, 0);
    check("rst.ir_wren", bus.ir_wren, 0);
    check("rst.pc_wren", bus.pc_wren, 0);
    check("rst.rd_wren", bus.rd_wren, 0);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check("rst.state", bus.state, 0);
    check("rst.instret", bus.instret, 0);
    check("rst.mem_fault", bus.mem_fault, 0);
    check("rst.illegal", bus.illegal, 0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    bus.mem_ready = 1'b0;
    retired = 0;
    @(negedge i_clk);
    check("rst.first_req", bus.mem_req, 1);
    @(posedge i_clk); #1;
    carry = 1;
  endtask

  task automatic run_instr(input logic [31:0] ins, input logic less, input logic eq,
                           input int fw, input int mw);
    exp_t  e;
    kind_t k;
    int    f;
    k = kind_of(ins);
    f = (fw > 3 - carry) ? 3 - carry : fw;
    e.id = txn_id; txn_id++;
    e.kind = k; e.instr = ins; e.trap = 1'b0;
    e.latency = f + carry; e.req_cnt = f + carry + 1;
    e.rd_cnt = 0; e.wr_cnt = 0; e.ir_cnt = 1; e.pc_sel = 1'b0;
    e.fault = 1'b0; e.illegal = 1'b0; e.chk_dec = (k != K_BAD);
    e.alu = model_alu(ins);
    e.opa = (ins[6:0] == 7'h37) ? 2'd2 :
            (ins[6:0] == 7'h17 || ins[6:0] == 7'h6F || ins[6:0] == 7'h63) ? 2'd1 : 2'd0;
    e.opb = (ins[6:0] != 7'h33);
    e.wb  = (k == K_LD) ? 2'd1 : (k == K_JMP) ? 2'd2 : 2'd0;
    e.br_un = (ins[6:0] == 7'h63) && (ins[14:13] == 2'b11);
    case (k)
      K_ALU: begin e.latency += 4; e.state = 3'd4; e.rd_cnt = 1; end
      K_BR:  begin e.latency += 3; e.state = 3'd2; e.pc_sel = model_taken(ins[14:12], less, eq); end
      K_JMP: begin e.latency += 3; e.state = 3'd2; e.rd_cnt = 1; e.pc_sel = 1'b1; end
      K_ST:  begin e.latency += 4 + mw; e.state = 3'd3; e.req_cnt += mw + 1; e.wr_cnt = mw + 1; end
      K_LD:  begin e.latency += 5 + mw; e.state = 3'd4; e.rd_cnt = 1; e.req_cnt += mw + 1; end
      default: begin
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
        e.latency += 3; e.state = 3'd7; e.trap = 1'b1; e.illegal = 1'b1;
`else
        e.latency += 2; e.state = 3'd1;
`endif
      end
    endcase
    e.instret = CNT_W'(retired);
    if (!e.trap) retired++;
    sb_q.push_back(e);

    bus.instr = ins; bus.br_less = less; bus.br_equal = eq;
    repeat (f) cyc(1'b0);
    cyc(1'b1);
    carry = 0;
    cyc(1'($urandom_range(0, 1)));          // DECODE
    if (k == K_BAD) begin
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
      cyc(1'($urandom_range(0, 1)));        // TRAP observed
      do_reset();
`endif
      return;
    end
    cyc(1'($urandom_range(0, 1)));          // EXEC
    if (k == K_LD || k == K_ST) begin
      repeat (mw) cyc(1'b0);
      cyc(1'b1);
      if (k == K_LD) cyc(1'($urandom_range(0, 1)));
    end else if (k == K_ALU) begin
      cyc(1'($urandom_range(0, 1)));        // WB
    end
  endtask

  task automatic run_timeout();
    exp_t e;
    e.id = txn_id; txn_id++;
    e.kind = K_TIMEOUT; e.instr = bus.instr; e.trap = 1'b1;
    e.latency = MEM_TIMEOUT + 1; e.req_cnt = MEM_TIMEOUT;
    e.rd_cnt = 0; e.wr_cnt = 0; e.ir_cnt = 0; e.pc_sel = 1'b0;
    e.state = 3'd7; e.fault = 1'b1; e.illegal = 1'b0; e.chk_dec = 1'b0;
    e.alu = 4'd0; e.opa = 2'd0; e.opb = 1'b0; e.wb = 2'd0; e.br_un = 1'b0;
    e.instret = CNT_W'(retired);
    sb_q.push_back(e);
    repeat (MEM_TIMEOUT - carry) cyc(1'b0);
    carry = 0;
    cyc(1'b0);                              // TRAP observed
    cyc(1'b1);                              // late ready must not leave TRAP
    check("timeout.held", bus.state, 3'd7);
    do_reset();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    ins = $urandom;
    case ($urandom_range(0, 9))
      0: begin
        ins[6:0] = 7'h33;
        case ($urandom_range(0, 2))
          0: ins[31:25] = 7'h00;
          1: ins[31:25] = 7'h20;
          default: ;
        endcase
      end
      1: begin
        ins[6:0] = 7'h13;
        if ($urandom_range(0, 1) == 1) ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      end
      2: ins[6:0] = 7'h37;
      3: ins[6:0] = 7'h17;
      4: ins[6:0] = 7'h6F;
      5: begin
        ins[6:0] = 7'h67;
        if ($urandom_range(0, 3) != 0) ins[14:12] = 3'd0;
      end
      6: ins[6:0] = 7'h63;
      7: ins[6:0] = 7'h03;
      8: ins[6:0] = 7'h23;
      default: ;
    endcase
    return ins;
  endfunction

  // ---------------- monitor ----------------
  int   m_cyc = 0, m_rd = 0, m_req = 0, m_wr = 0, m_ir = 0;
  logic trap_seen = 1'b0;
  logic wd_fired  = 1'b0;

  initial begin
    exp_t  e;
    string n;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        m_cyc = 0; m_rd = 0; m_req = 0; m_wr = 0; m_ir = 0;
        trap_seen = 1'b0;
      end else begin
        m_cyc++;
        if (bus.rd_wren)  m_rd++;
        if (bus.mem_req)  m_req++;
        if (bus.mem_wren) m_wr++;
        if (bus.ir_wren)  m_ir++;
        if (bus.pc_wren || (bus.state == 3'd7 && !trap_seen)) begin
          if (bus.state == 3'd7) trap_seen = 1'b1;
          if (sb_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_event actual=state%0d required=no_event", bus.state);
          end else begin
            e = sb_q.pop_front();
            n = $sformatf("t%0d", e.id);
            $display("txn %0d kind=%s instr=%08h latency=%0d", e.id, e.kind.name(), e.instr, m_cyc);
            check({n, ".latency"}, m_cyc, e.latency);
            check({n, ".state"}, bus.state, e.state);
            check({n, ".pc_wren"}, bus.pc_wren, !e.trap);
            check({n, ".rd_cnt"}, m_rd, e.rd_cnt);
            check({n, ".req_cnt"}, m_req, e.req_cnt);
            check({n, ".wr_cnt"}, m_wr, e.wr_cnt);
            check({n, ".ir_cnt"}, m_ir, e.ir_cnt);
            check({n, ".instret"}, bus.instret, e.instret);
            check({n, ".mem_fault"}, bus.mem_fault, e.fault);
            check({n, ".illegal"}, bus.illegal, e.illegal);
            if (!e.trap) check({n, ".pc_sel"}, bus.pc_sel, e.pc_sel);
            if (e.chk_dec) begin
              check({n, ".alu_op"}, bus.alu_op, e.alu);
              check({n, ".opa_sel"}, bus.opa_sel, e.opa);
              check({n, ".opb_sel"}, bus.opb_sel, e.opb);
              check({n, ".wb_sel"}, bus.wb_sel, e.wb);
              check({n, ".br_un"}, bus.br_un, e.br_un);
            end
          end
          m_cyc = 0; m_rd = 0; m_req = 0; m_wr = 0; m_ir = 0;
        end else if (!trap_seen && m_cyc > 30 && !wd_fired) begin
          wd_fired = 1'b1;
          checks++; failures++;
          $display("FAIL watchdog actual=%0d_cycles required=retire_within_30", m_cyc);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] ins;
    bus.instr = 32'h0; bus.br_less = 1'b0; bus.br_equal = 1'b0; bus.mem_ready = 1'b0;
    do_reset();

    run_instr(32'h002081B3, 1'b0, 1'b0, 0, 0);   // ADD after reset (one carried wait)
    run_instr(32'h002081B3, 1'b0, 1'b0, 0, 0);   // ADD, zero wait
    run_instr(32'h0020C463, 1'b1, 1'b0, 0, 0);   // BLT taken
    run_instr(32'h0020E463, 1'b0, 1'b0, 0, 0);   // BLTU not taken
    run_instr(32'h0000A283, 1'b0, 1'b0, 0, 3);   // LW, 3 MEM waits
    run_instr(32'h0000A023, 1'b0, 1'b0, 3, 3);   // SW, ready on the timeout-boundary cycle

    for (int i = 0; i < 70; i++) begin
      ins = rand_instr();
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
      while (kind_of(ins) == K_BAD) ins = rand_instr();
`endif
      run_instr(ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3));
    end

    run_instr(32'hFFFFFFFF, 1'b0, 1'b0, 0, 0);   // illegal encoding
    run_timeout();
    for (int i = 0; i < 5; i++)
      run_instr(32'h002081B3, 1'b0, 1'b0, $urandom_range(0, 2), 0);

    repeat (2) @(posedge i_clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
